// File: rtl/neighbourhood_window.sv
// neighbourhood_window
//   Streaming front end for the neighbour popcount. Takes one generation of a
//   GRID_W x GRID_H grid as a row-major serial bit stream and emits, for every
//   cell, the cell itself plus its eight compass neighbours. Cells outside the
//   grid read as dead (no wrap-around).
//
// Ports
//   CLK, RST_N            clock (rising edge), asynchronous active-low reset
//   IN_VALID/IN_READY     input handshake, IN_CELL carries one cell bit
//   OUT_VALID/OUT_READY   output handshake for the window registers
//   CENTER, N..NW         window bits of cell (OUT_ROW, OUT_COL)
//   OUT_ROW, OUT_COL      coordinates of the emitted cell
//   OUT_LAST              emitted cell is the last of the frame
//   dbg_state             current FSM state (FILL=0, RUN=1, FLUSH=2)
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. Valid never depends on ready; once OUT_VALID is high the window
// and coordinates hold until the consumer takes them.

module neighbourhood_window #(
  parameter int GRID_W = 8,
  parameter int GRID_H = 8
) (
  input  logic                      CLK,
  input  logic                      RST_N,
  input  logic                      IN_VALID,
  output logic                      IN_READY,
  input  logic                      IN_CELL,
  output logic                      OUT_VALID,
  input  logic                      OUT_READY,
  output logic                      CENTER,
  output logic                      N,
  output logic                      NE,
  output logic                      E,
  output logic                      SE,
  output logic                      S,
  output logic                      SW,
  output logic                      W,
  output logic                      NW,
  output logic [$clog2(GRID_H)-1:0] OUT_ROW,
  output logic [$clog2(GRID_W)-1:0] OUT_COL,
  output logic                      OUT_LAST,
  output logic [1:0]                dbg_state
);

  localparam int SR_LEN = 2 * GRID_W + 3;
  localparam int CW     = $clog2(GRID_W * GRID_H);
  localparam int RWD    = $clog2(GRID_H);
  localparam int CLW    = $clog2(GRID_W);

  // Tap positions in the post-shift window: index 0 is the newest cell
  // (k+W+1), index j holds cell k+W+1-j, so the centre sits at W+1.
  localparam int TAP_SE = 0;
  localparam int TAP_S  = 1;
  localparam int TAP_SW = 2;
  localparam int TAP_E  = GRID_W;
  localparam int TAP_C  = GRID_W + 1;
  localparam int TAP_W  = GRID_W + 2;
  localparam int TAP_NE = 2 * GRID_W;
  localparam int TAP_N  = 2 * GRID_W + 1;
  localparam int TAP_NW = 2 * GRID_W + 2;

  localparam logic [CW-1:0]  CNT_W    = CW'(GRID_W);
  localparam logic [CW-1:0]  CNT_LAST = CW'(GRID_W * GRID_H - 1);
  localparam logic [RWD-1:0] ROW_LAST = RWD'(GRID_H - 1);
  localparam logic [CLW-1:0] COL_LAST = CLW'(GRID_W - 1);

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       in_cnt, cnt_d;
  logic [SR_LEN-1:0]   sr;
  logic [SR_LEN-1:0]   win;
  logic [RWD-1:0]      load_row;
  logic [CLW-1:0]      load_col;

  logic stall, accept, flush_step, do_shift, do_load, last_load, shift_bit;
  logic top, bot, lft, rgt;

  assign stall      = OUT_VALID & ~OUT_READY;
  assign IN_READY   = ~stall & (state_q != FLUSH);
  assign accept     = IN_VALID & IN_READY;
  assign flush_step = (state_q == FLUSH) & ~stall;
  assign do_shift   = accept | flush_step;
  assign do_load    = ((state_q == RUN) & accept) | flush_step;
  // In FLUSH the counter tracks flush loads; the (W+1)-th is the frame's last.
  assign last_load  = (state_q == FLUSH) & (in_cnt == CNT_W);
  assign shift_bit  = (state_q == FLUSH) ? 1'b0 : IN_CELL;
  // Window as it will look after this cycle's shift, so the load and the
  // shift happen on the same edge.
  assign win        = {sr[SR_LEN-2:0], shift_bit};

  assign top = (load_row == '0);
  assign bot = (load_row == ROW_LAST);
  assign lft = (load_col == '0);
  assign rgt = (load_col == COL_LAST);

  assign dbg_state = state_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= FILL;
      in_cnt  <= '0;
    end else begin
      state_q <= state_d;
      in_cnt  <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = in_cnt;
    case (state_q)
      FILL: begin
        if (accept) begin
          cnt_d = in_cnt + CW'(1);
          if (in_cnt == CNT_W) state_d = RUN;
        end
      end
      RUN: begin
        if (accept) begin
          if (in_cnt == CNT_LAST) begin
            state_d = FLUSH;
            cnt_d   = '0;
          end else begin
            cnt_d = in_cnt + CW'(1);
          end
        end
      end
      FLUSH: begin
        if (flush_step) begin
          if (in_cnt == CNT_W) begin
            state_d = FILL;
            cnt_d   = '0;
          end else begin
            cnt_d = in_cnt + CW'(1);
          end
        end
      end
      default: begin
        state_d = FILL;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sr        <= '0;
      load_row  <= '0;
      load_col  <= '0;
      OUT_VALID <= 1'b0;
      CENTER    <= 1'b0;
      N         <= 1'b0;
      NE        <= 1'b0;
      E         <= 1'b0;
      SE        <= 1'b0;
      S         <= 1'b0;
      SW        <= 1'b0;
      W         <= 1'b0;
      NW        <= 1'b0;
      OUT_ROW   <= '0;
      OUT_COL   <= '0;
      OUT_LAST  <= 1'b0;
    end else begin
      if (do_shift) sr <= win;
      if (do_load) begin
        CENTER    <= win[TAP_C];
        N         <= win[TAP_N]  & ~top;
        NE        <= win[TAP_NE] & ~top & ~rgt;
        E         <= win[TAP_E]  & ~rgt;
        SE        <= win[TAP_SE] & ~bot & ~rgt;
        S         <= win[TAP_S]  & ~bot;
        SW        <= win[TAP_SW] & ~bot & ~lft;
        W         <= win[TAP_W]  & ~lft;
        NW        <= win[TAP_NW] & ~top & ~lft;
        OUT_ROW   <= load_row;
        OUT_COL   <= load_col;
        OUT_LAST  <= last_load;
        OUT_VALID <= 1'b1;
        if (load_col == COL_LAST) begin
          load_col <= '0;
          load_row <= (load_row == ROW_LAST) ? '0 : load_row + RWD'(1);
        end else begin
          load_col <= load_col + CLW'(1);
        end
      end else if (OUT_READY) begin
        OUT_VALID <= 1'b0;
      end
    end
  end

endmodule
